// File: rtl/add_round_key_stage_if.sv
// rtl/add_round_key_stage_if.sv - key-load and state-block signals for the AddRoundKey stage
//
// Groups every non-clock/reset signal of add_round_key_stage.
//   master : the side that loads keys and sends state blocks.
//   slave  : add_round_key_stage itself.
// Key-load group : key_load, key_valid_in, key_in -> keys_ready
// Data group     : valid_in, first_in, data_in -> valid_out, data_out, round_out, last_out, err_out
interface add_round_key_stage_if #(
    parameter int DATA_W = 128
);
    logic              key_load;
    logic              key_valid_in;
    logic [DATA_W-1:0] key_in;
    logic              keys_ready;
    logic              valid_in;
    logic              first_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        round_out;
    logic              last_out;
    logic              err_out;

    modport master (
        output key_load, key_valid_in, key_in, valid_in, first_in, data_in,
        input  keys_ready, valid_out, data_out, round_out, last_out, err_out
    );

    modport slave (
        input  key_load, key_valid_in, key_in, valid_in, first_in, data_in,
        output keys_ready, valid_out, data_out, round_out, last_out, err_out
    );
endinterface

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - AES AddRoundKey stage with an NR+1 entry round-key store
//
// Ports:
//   clk   : rising-edge clock.
//   reset : asynchronous active-low reset.
//   bus   : add_round_key_stage_if.slave
//           key_load / key_valid_in / key_in load a schedule, keys_ready when full.
//           valid_in / first_in / data_in carry one state block per beat; the stage
//           returns data_in XOR round key one cycle later on data_out with its
//           round_out, last_out and valid_out. err_out pulses when a beat arrives
//           before a full schedule is stored.
module add_round_key_stage #(
    parameter int DATA_W = 128,
    parameter int NR     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    add_round_key_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t            state;
    logic [3:0]        wr_ptr;
    logic [3:0]        rnd;
    logic [DATA_W-1:0] store [0:NR];

    logic              store_we;
    logic [3:0]        store_addr;
    logic [3:0]        k;
    logic              beat_ok;

    // A key_load cycle may carry key 0 itself, so it writes slot 0 directly.
    assign store_we   = bus.key_valid_in && (bus.key_load || state == LOAD);
    assign store_addr = bus.key_load ? 4'd0 : wr_ptr;

    // first_in restarts the block at round 0 regardless of the running counter.
    assign k       = bus.first_in ? 4'd0 : rnd;
    assign beat_ok = bus.valid_in && (state == READY);

    // The key store carries no reset; it is only read once READY has been reached.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[store_addr] <= bus.key_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= EMPTY;
            wr_ptr         <= 4'd0;
            rnd            <= 4'd0;
            bus.keys_ready <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.data_out   <= '0;
            bus.round_out  <= 4'd0;
            bus.last_out   <= 1'b0;
            bus.err_out    <= 1'b0;
        end else begin
            bus.valid_out <= beat_ok;
            bus.err_out   <= bus.valid_in && (state != READY);

            if (beat_ok) begin
                bus.data_out  <= bus.data_in ^ store[k];
                bus.round_out <= k;
                bus.last_out  <= (k == LAST_RND);
                rnd           <= (k == LAST_RND) ? 4'd0 : k + 4'd1;
            end

            // key_load wins over the round update above: a beat in the same
            // cycle still uses the old key, but the round position restarts.
            if (bus.key_load) begin
                state          <= LOAD;
                wr_ptr         <= bus.key_valid_in ? 4'd1 : 4'd0;
                rnd            <= 4'd0;
                bus.keys_ready <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (bus.key_valid_in) begin
                            wr_ptr <= wr_ptr + 4'd1;
                            if (wr_ptr == LAST_RND) begin
                                state          <= READY;
                                bus.keys_ready <= 1'b1;
                            end
                        end
                    end
                    READY: begin
                        bus.keys_ready <= 1'b1;
                    end
                    default: begin
                        bus.keys_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 128, data and key width in bits.
REQ-002 SHALL have parameter NR, default 10, last round index; the key store holds NR+1 keys.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_load, input, 1, start loading a new key schedule.
REQ-006 SHALL have port key_valid_in, input, 1, key_in carries the next round key.
REQ-007 SHALL have port key_in, input, DATA_W, round key; byte 0 in bits [DATA_W-1:DATA_W-8].
REQ-008 SHALL have port keys_ready, output, 1, full schedule stored.
REQ-009 SHALL have port valid_in, input, 1, data_in valid; one state block per beat.
REQ-010 SHALL have port first_in, input, 1, this beat is round 0 of a new block.
REQ-011 SHALL have port data_in, input, DATA_W, state, same byte order as key_in.
REQ-012 SHALL have port valid_out, output, 1, data_out valid.
REQ-013 SHALL have port data_out, output, DATA_W, state XOR round key.
REQ-014 SHALL have port round_out, output, 4, round index used for data_out.
REQ-015 SHALL have port last_out, output, 1, data_out is the final round (round_out == NR).
REQ-016 SHALL have port err_out, output, 1, one-cycle pulse: valid_in dropped because keys not ready.

Function
REQ-017 SHALL implement FSM states EMPTY, LOAD, READY; keys_ready = 1 only in READY.
REQ-018 SHALL move from any state to LOAD on key_load: wr_ptr = 0, rnd = 0.
REQ-019 SHALL, in LOAD on key_valid_in, write key_in to store[wr_ptr] and increment wr_ptr.
REQ-020 SHALL, on key_load and key_valid_in in the same cycle, write key_in to store[0] and set wr_ptr = 1.
REQ-021 SHALL move LOAD to READY on the cycle that writes store[NR]; keys_ready rises on the next edge.
REQ-022 SHALL ignore key_valid_in in EMPTY and READY; the store is unchanged.
REQ-023 SHALL, in READY on valid_in, register data_out = data_in XOR store[k] with 1-cycle latency, where k = 0 if first_in else rnd.
REQ-024 SHALL, on such a beat, register round_out = k and last_out = (k == NR).
REQ-025 SHALL update rnd to 0 when k == NR, else k+1.
REQ-026 SHALL register valid_out = valid_in AND (state == READY) every cycle.
REQ-027 SHALL, on valid_in outside READY, pulse err_out for one cycle, hold valid_out 0, and leave data_out, round_out, last_out and rnd unchanged.
REQ-028 SHALL hold data_out, round_out and last_out when valid_in is 0; last_out is meaningful only with valid_out.
REQ-029 SHALL, when key_load coincides with valid_in in READY, process the beat with the old store and old k, and then enter LOAD with rnd = 0.
REQ-030 SHALL accept back-to-back valid_in every cycle with no bubbles.

Reset
REQ-031 SHALL, on reset low, immediately enter EMPTY with wr_ptr = 0, rnd = 0, keys_ready = 0, valid_out = 0, data_out = 0, round_out = 0, last_out = 0, err_out = 0.
REQ-032 SHALL not require the key store itself to be reset; it is unreadable until READY.
REQ-033 SHALL, on reset mid-LOAD or mid-block, discard the partial schedule and round position; a full reload is required.

Verification
REQ-034 SHALL cover: load 11 keys with key[0] = 2b7e151628aed2a6abf7158809cf4f3c; valid_in with first_in and data 3243f6a8885a308d313198a2e0370734 -> next cycle data_out = 193de3bea0f4e22b9ac68d2ae9f84808, round_out = 0, last_out = 0.
REQ-035 SHALL cover: key[i] = i replicated per byte; 11 consecutive beats of data 0 -> round_out 0..10, data_out = key[round_out], last_out = 1 only on round 10; a 12th beat -> round_out = 0.
REQ-036 SHALL cover: valid_in after reset with no keys loaded -> err_out = 1 for exactly one cycle, valid_out = 0, and the later first beat uses round 0.
REQ-037 SHALL cover: key_load after 5 keys, then 11 new keys -> keys_ready rises one cycle after the 11th; outputs use only the new keys.
REQ-038 SHALL cover: first_in asserted on the beat after round 4 -> round_out = 0 and the following beat gives round_out = 1.
REQ-039 SHALL cover: reset asserted during round 6 -> all outputs 0 at once, state EMPTY, keys_ready = 0.
